// File: rtl/traffic_pkg.sv
// Shared state encodings and light codes for the intersection phase controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G   = 3'd0,
        NS_Y   = 3'd1,
        RED_A  = 3'd2,
        WALK_S = 3'd3,
        EW_G   = 3'd4,
        EW_Y   = 3'd5,
        RED_B  = 3'd6
    } state_t;

    // {red, yellow, green}
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Cycles-in-phase counter: clears synchronously, saturates at all-ones instead of wrapping.
module phase_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    output logic [TIMER_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != {TIMER_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: NS main road, EW side road and pedestrian walk,
// with latched demand and lights decoded from the registered state.
//
// state  | meaning
// NS_G   | north-south green (default, held until demand after min green)
// NS_Y   | north-south yellow
// RED_A  | all-red clearance after NS
// WALK_S | pedestrian walk, all vehicles red
// EW_G   | east-west green (fixed length)
// EW_Y   | east-west yellow
// RED_B  | all-red clearance before NS, also the reset state
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NS_MIN_GREEN = 8,
    parameter int EW_GREEN     = 6,
    parameter int YELLOW       = 3,
    parameter int ALL_RED      = 2,
    parameter int WALK         = 5,
    parameter int TIMER_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ped_req,
    input  logic               ew_car,
    output logic [2:0]         ns_light,
    output logic [2:0]         ew_light,
    output logic               walk,
    output logic [2:0]         state_o,
    output logic [TIMER_W-1:0] phase_tmr
);

    // A phase of duration D exits on the edge where the timer reads D-1.
    localparam logic [TIMER_W-1:0] T_NS_MIN = TIMER_W'(NS_MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_EW_G   = TIMER_W'(EW_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_YEL    = TIMER_W'(YELLOW - 1);
    localparam logic [TIMER_W-1:0] T_RED    = TIMER_W'(ALL_RED - 1);
    localparam logic [TIMER_W-1:0] T_WALK   = TIMER_W'(WALK - 1);

    state_t             state;
    state_t             state_nx;
    logic               ped_pend;
    logic               ew_pend;
    logic               tmr_clr;
    logic [TIMER_W-1:0] timer;

    phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .count (timer)
    );

    always_comb begin
        state_nx = state;
        case (state)
            NS_G:   if (timer >= T_NS_MIN && (ped_pend || ew_pend)) state_nx = NS_Y;
            NS_Y:   if (timer == T_YEL)  state_nx = RED_A;
            RED_A:  if (timer == T_RED)  state_nx = ped_pend ? WALK_S : EW_G;
            WALK_S: if (timer == T_WALK) state_nx = ew_pend ? EW_G : RED_B;
            EW_G:   if (timer == T_EW_G) state_nx = EW_Y;
            EW_Y:   if (timer == T_YEL)  state_nx = RED_B;
            RED_B:  if (timer == T_RED)  state_nx = NS_G;
            default:                     state_nx = RED_B;
        endcase
    end

    assign tmr_clr = (state_nx != state);

    // A request arriving on the entry edge survives the clear (set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RED_B;
            ped_pend <= 1'b0;
            ew_pend  <= 1'b0;
        end else begin
            state    <= state_nx;
            ped_pend <= ped_req | (ped_pend & ~(state_nx == WALK_S && state != WALK_S));
            ew_pend  <= ew_car  | (ew_pend  & ~(state_nx == EW_G   && state != EW_G));
        end
    end

    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
        case (state)
            NS_G:    ns_light = LIGHT_GRN;
            NS_Y:    ns_light = LIGHT_YEL;
            EW_G:    ew_light = LIGHT_GRN;
            EW_Y:    ew_light = LIGHT_YEL;
            WALK_S:  walk     = 1'b1;
            default: ;
        endcase
    end

    assign state_o   = state;
    assign phase_tmr = timer;

endmodule
